uart_receiver: RTL

Serial receive stage of the UART, directly downstream of the baud-rate generator. It consumes the 16x-oversampling `sample_ENABLE` tick and reconstructs 8N1 or 8-bit-plus-parity frames from the asynchronous `RxD` line. Each bit is decided by a mid-bit majority vote. The block delivers a byte with a one-cycle valid strobe and parity/framing error flags. On every accepted start edge it also drives `baud_restart`, which re-phases the baud generator's tick counter so that oversampling ticks align with the incoming frame.

---
 rtl/uart_receiver.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 / 8-bit-plus-parity UART receiver on a 16x oversampling tick.
// Each bit is a 2-of-3 majority vote of the samples at ticks 7, 8 and 9.
module uart_receiver #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_EN,
  input  logic       RxD,
  input  logic       sample_ENABLE,
  output logic       baud_restart,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_rx_meta, r_rxs, r_rxs_d;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic       r_s7, r_s8;
  logic [7:0] r_shift;
  logic       r_par_err;
  logic [7:0] r_data;
  logic       r_valid, r_perr, r_ferr, r_baud_restart;

  logic w_edge, w_dec, w_wrap, w_maj;
  logic w_start_acc, w_shift_en, w_par_en, w_done, w_cnt_clr, w_cnt_en;

  assign w_edge = r_rxs_d & ~r_rxs;
  assign w_dec  = sample_ENABLE && (r_tick_cnt == 4'd9);
  assign w_wrap = sample_ENABLE && (r_tick_cnt == 4'd15);
  // Third vote is the live sample taken on the deciding tick.
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      r_rx_meta <= RxD;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!Rx_EN) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_edge) w_next = S_START;
        S_START:  if (w_dec && w_maj) w_next = S_IDLE;
                  else if (w_wrap) w_next = S_DATA;
        S_DATA:   if (w_wrap && (r_bit_idx == 3'd7))
                    w_next = PARITY_EN ? S_PARITY : S_STOP;
        S_PARITY: if (w_wrap) w_next = S_STOP;
        S_STOP:   if (w_dec) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_start_acc = Rx_EN && (r_state == S_IDLE) && w_edge;
    w_shift_en  = Rx_EN && (r_state == S_DATA) && w_dec;
    w_par_en    = Rx_EN && (r_state == S_PARITY) && w_dec;
    w_done      = Rx_EN && (r_state == S_STOP) && w_dec;
    w_cnt_clr   = !Rx_EN || w_start_acc;
    w_cnt_en    = (r_state != S_IDLE) && sample_ENABLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt     <= 4'd0;
      r_bit_idx      <= 3'd0;
      r_s7           <= 1'b1;
      r_s8           <= 1'b1;
      r_shift        <= 8'h00;
      r_par_err      <= 1'b0;
      r_data         <= 8'h00;
      r_valid        <= 1'b0;
      r_perr         <= 1'b0;
      r_ferr         <= 1'b0;
      r_baud_restart <= 1'b0;
    end else begin
      r_baud_restart <= w_start_acc;
      r_valid        <= w_done;
      if (w_cnt_clr) begin
        r_tick_cnt <= 4'd0;
        r_bit_idx  <= 3'd0;
      end else if (w_cnt_en) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
        if ((r_state == S_DATA) && (r_tick_cnt == 4'd15))
          r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (Rx_EN && w_cnt_en) begin
        if (r_tick_cnt == 4'd7) r_s7 <= r_rxs;
        if (r_tick_cnt == 4'd8) r_s8 <= r_rxs;
      end
      if (w_shift_en) r_shift <= {w_maj, r_shift[7:1]};
      if (w_start_acc)   r_par_err <= 1'b0;
      else if (w_par_en) r_par_err <= (^r_shift) ^ w_maj ^ PARITY_ODD;
      if (w_done) begin
        r_data <= r_shift;
        r_perr <= PARITY_EN ? r_par_err : 1'b0;
        r_ferr <= ~w_maj;
      end
    end
  end

  assign baud_restart = r_baud_restart;
  assign Rx_DATA      = r_data;
  assign Rx_VALID     = r_valid;
  assign Rx_PERROR    = r_perr;
  assign Rx_FERROR    = r_ferr;

endmodule
